ahblite_lcd_8080: RTL and testbench

//  AHB-Lite slave driving an 8080-style parallel LCD panel with hardware-generated write strobes.

---
 rtl/ahblite_lcd_8080.sv | 229 ++++++++++++++++++++++
 tb/tb_ahblite_lcd_8080.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_lcd_8080.sv
// AHB-Lite slave that replays queued command/data words onto an 8080-style LCD bus with timed WR strobes.
// Define AHBLITE_LCD_IRQ_EN to add the IRQ output, CTRL.IE and the sticky STATUS.DONE flag.
module ahblite_lcd_8080 #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int WR_LO_RST  = 2,
  parameter int WR_HI_RST  = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  output logic              LCD_CS,
  output logic              LCD_RS,
  output logic              LCD_WR,
  output logic              LCD_RD,
  output logic              LCD_RST,
  output logic              LCD_BL_CTR,
  output logic [DATA_W-1:0] LCD_DATA
`ifdef AHBLITE_LCD_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, WR_LO, WR_HI} state_t;

  logic              ph_sel, ph_write;
  logic [2:0]        ph_addr;
  logic              ctrl_cs, ctrl_rst, ctrl_bl, ctrl_ie, done;
  logic [7:0]        tim_lo, tim_hi;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  state_t            state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic              wr_n, rs_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_act, rd_act, push_req, push, pop, full, empty, busy;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  // A zero-length phase still lasts one cycle; returns the counter preload.
  function automatic logic [7:0] phase_m1(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_sel   <= 1'b0;
      ph_write <= 1'b0;
      ph_addr  <= 3'd0;
    end else if (HREADY) begin
      ph_sel   <= HSEL & HTRANS[1];
      ph_write <= HWRITE;
      ph_addr  <= HADDR[4:2];
    end
  end

  assign wr_act   = ph_sel & ph_write;
  assign rd_act   = ph_sel & ~ph_write;
  assign push_req = wr_act & ((ph_addr == 3'd2) | (ph_addr == 3'd3));
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign busy     = (state != IDLE) | ~empty;
  // A pop in the same cycle frees the slot, so a push at full does not stall then.
  assign push      = push_req & (~full | pop);
  assign HREADYOUT = ~(push_req & full & ~pop);
  assign HRESP     = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_cs  <= 1'b0;
      ctrl_rst <= 1'b1;
      ctrl_bl  <= 1'b0;
      tim_lo   <= 8'(WR_LO_RST);
      tim_hi   <= 8'(WR_HI_RST);
    end else if (wr_act) begin
      if (ph_addr == 3'd0) begin
        ctrl_cs  <= HWDATA[0];
        ctrl_rst <= HWDATA[1];
        ctrl_bl  <= HWDATA[2];
      end
      if (ph_addr == 3'd1) begin
        tim_lo <= HWDATA[7:0];
        tim_hi <= HWDATA[15:8];
      end
    end
  end

`ifdef AHBLITE_LCD_IRQ_EN
  logic done_set, done_clr;
  assign done_set = (state == WR_HI) && (state_d == IDLE);
  assign done_clr = wr_act && (ph_addr == 3'd4) && HWDATA[3];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_ie <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (wr_act && (ph_addr == 3'd0)) ctrl_ie <= HWDATA[3];
      done <= done_set | (done & ~done_clr);
    end
  end

  assign IRQ = ctrl_ie & done;
`else
  assign ctrl_ie = 1'b0;
  assign done    = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (push) mem[wptr] <= {ph_addr[0], HWDATA[DATA_W-1:0]};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = WR_LO;
        cnt_d   = phase_m1(tim_lo);
      end
      WR_LO: begin
        if (cnt == 8'd0) begin
          state_d = WR_HI;
          cnt_d   = phase_m1(tim_hi);
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      WR_HI: begin
        if (cnt == 8'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe and panel bus are registered so the pins never glitch on state decode.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      wr_n   <= 1'b1;
      rs_q   <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wr_n  <= (state_d != WR_LO);
      if (pop) begin
        rs_q   <= mem[rptr][DATA_W];
        data_q <= mem[rptr][DATA_W-1:0];
      end
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_act) begin
      case (ph_addr)
        3'd0: HRDATA[3:0] = {ctrl_ie, ctrl_bl, ctrl_rst, ctrl_cs};
        3'd1: HRDATA[15:0] = {tim_hi, tim_lo};
        3'd4: begin
          HRDATA[3:0]    = {done, empty, full, busy};
          HRDATA[8 +: LW] = level;
        end
        default: HRDATA = 32'd0;
      endcase
    end
  end

  assign LCD_CS     = ~ctrl_cs;
  assign LCD_RS     = rs_q;
  assign LCD_WR     = wr_n;
  assign LCD_RD     = 1'b1;
  assign LCD_RST    = ~ctrl_rst;
  assign LCD_BL_CTR = ctrl_bl;
  assign LCD_DATA   = data_q;

endmodule

// File: tb/tb_ahblite_lcd_8080.sv
// Directed bench for ahblite_lcd_8080: register access, strobe timing, FIFO stall, async reset.
module tb_ahblite_lcd_8080;
  localparam int DATA_W = 16;

  logic              HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0]       HADDR, HWDATA, HRDATA;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [3:0]        HPROT;
  logic              LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
  logic [DATA_W-1:0] LCD_DATA;
`ifdef AHBLITE_LCD_IRQ_EN
  logic              IRQ;
`endif

  ahblite_lcd_8080 #(.DATA_W(DATA_W), .FIFO_DEPTH(8), .WR_LO_RST(2), .WR_HI_RST(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
    .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR), .LCD_DATA(LCD_DATA)
`ifdef AHBLITE_LCD_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records {RS,DATA}, low width and preceding high width per strobe.
  logic [16:0] s_word[$];
  int          s_lo[$];
  int          s_gap[$];
  logic        wr_prev = 1'b1;
  int          lo_cnt = 0, hi_cnt = 0, gap_at_fall = 0;

  always @(negedge HCLK) begin
    if (LCD_WR === 1'b0) begin
      if (wr_prev) begin
        gap_at_fall = hi_cnt;
        lo_cnt = 0;
      end
      lo_cnt++;
    end else begin
      if (!wr_prev) begin
        s_word.push_back({LCD_RS, LCD_DATA});
        s_lo.push_back(lo_cnt);
        s_gap.push_back(gap_at_fall);
        hi_cnt = 0;
      end
      hi_cnt++;
    end
    wr_prev = LCD_WR;
  end

  logic [31:0] b_addr [16];
  logic [31:0] b_data [16];

  // Pipelined write burst; called and returns at #1 after a rising edge.
  task automatic ahb_burst(input int n, output int stalls);
    int guard;
    stalls = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = b_addr[i];
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
      if (i > 0) HWDATA = b_data[i-1];
      guard = 0;
      while (HREADYOUT !== 1'b1 && guard < 1000) begin
        @(posedge HCLK); #1;
        stalls++;
        guard++;
      end
      if (guard >= 1000) check_val("hready_timeout", 32'd0, 32'd1);
      @(posedge HCLK); #1;
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    int st;
    b_addr[0] = a;
    b_data[0] = d;
    ahb_burst(1, st);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int k = 0; k < 500; k++) begin
      ahb_read(32'h10, st);
      if (st[0] == 1'b0) break;
    end
    check_val(tag, {31'd0, st[0]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  int base, stalls, cnt0;

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'b0011; HWRITE = 1'b0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // T1: reset state
    check_val("t1_hreadyout", HREADYOUT, 1);
    check_val("t1_lcd_cs", LCD_CS, 1);
    check_val("t1_lcd_wr", LCD_WR, 1);
    check_val("t1_lcd_rd", LCD_RD, 1);
    check_val("t1_lcd_rst", LCD_RST, 0);
    check_val("t1_lcd_bl", LCD_BL_CTR, 0);
    check_val("t1_lcd_rs", LCD_RS, 0);
    check_val("t1_lcd_data", LCD_DATA, 0);
    ahb_read(32'h00, rd); check_val("t1_ctrl", rd, 32'h2);
    ahb_read(32'h04, rd); check_val("t1_timing", rd, 32'h0202);
    ahb_read(32'h10, rd); check_val("t1_status", rd, 32'h4);
    ahb_read(32'h08, rd); check_val("t1_cmd_rd", rd, 32'h0);
    ahb_read(32'h1C, rd); check_val("t1_unmapped_rd", rd, 32'h0);

    // CTRL drives pins directly; IE bit exists only with the IRQ option
    ahb_write(32'h00, 32'h0D);
    check_val("ctrl_lcd_cs", LCD_CS, 0);
    check_val("ctrl_lcd_rst", LCD_RST, 1);
    check_val("ctrl_lcd_bl", LCD_BL_CTR, 1);
    ahb_read(32'h00, rd);
`ifdef AHBLITE_LCD_IRQ_EN
    check_val("ctrl_readback", rd, 32'hD);
`else
    check_val("ctrl_readback", rd, 32'h5);
`endif
    ahb_write(32'h10, 32'hFFFF);
    ahb_write(32'h14, 32'h1234);
    ahb_read(32'h10, rd); check_val("ro_write_ignored", rd, 32'h4);
    ahb_read(32'h04, rd); check_val("unmapped_write_ignored", rd, 32'h0202);

    // T2: two strobes, 2 low / 3 high
    ahb_write(32'h04, 32'h0302);
    ahb_read(32'h04, rd); check_val("t2_timing", rd, 32'h0302);
    base = s_word.size();
    b_addr[0] = 32'h08; b_data[0] = 32'h002C;
    b_addr[1] = 32'h0C; b_data[1] = 32'hF800;
    ahb_burst(2, stalls);
    wait_idle("t2_idle");
    check_val("t2_count", s_word.size() - base, 2);
    check_val("t2_word0", s_word[base], {1'b0, 16'h002C});
    check_val("t2_lo0", s_lo[base], 2);
    check_val("t2_word1", s_word[base+1], {1'b1, 16'hF800});
    check_val("t2_lo1", s_lo[base+1], 2);
    check_val("t2_gap1", s_gap[base+1], 4);
    ahb_read(32'h10, rd); check_val("t2_status", rd, 32'h4);
    check_val("t2_hold_rs", LCD_RS, 1);
    check_val("t2_hold_data", LCD_DATA, 16'hF800);

    // T3: overfill the FIFO with a slow strobe so the tail of the burst stalls
    ahb_write(32'h04, 32'h0808);
    base = s_word.size();
    for (int i = 0; i < 10; i++) begin
      b_addr[i] = 32'h0C;
      b_data[i] = 32'hA000 + i;
    end
    ahb_burst(10, stalls);
    check_val("t3_stalled", {31'd0, stalls > 0}, 32'd1);
    ahb_read(32'h10, rd); check_val("t3_status_full", rd, 32'h0803);
    wait_idle("t3_idle");
    check_val("t3_count", s_word.size() - base, 10);
    for (int i = 0; i < 10; i++)
      if (base + i < s_word.size())
        check_val($sformatf("t3_word%0d", i), s_word[base+i], {1'b1, 16'hA000 + 16'(i)});

    // T4: zero timing behaves as one cycle each
    ahb_write(32'h04, 32'h0000);
    base = s_word.size();
    b_addr[0] = 32'h0C; b_data[0] = 32'h1111;
    b_addr[1] = 32'h08; b_data[1] = 32'h2222;
    b_addr[2] = 32'h0C; b_data[2] = 32'h3333;
    ahb_burst(3, stalls);
    wait_idle("t4_idle");
    check_val("t4_count", s_word.size() - base, 3);
    check_val("t4_lo0", s_lo[base], 1);
    check_val("t4_lo1", s_lo[base+1], 1);
    check_val("t4_gap1", s_gap[base+1], 2);
    check_val("t4_lo2", s_lo[base+2], 1);
    check_val("t4_gap2", s_gap[base+2], 2);
    check_val("t4_word1", s_word[base+1], {1'b0, 16'h2222});

    // T5: async reset during WR_LO with four entries still queued
    ahb_write(32'h04, 32'h0404);
    for (int i = 0; i < 5; i++) begin
      b_addr[i] = 32'h0C;
      b_data[i] = 32'h5000 + i;
    end
    ahb_burst(5, stalls);
    check_val("t5_in_wr_lo", LCD_WR, 0);
    HRESETn = 1'b0;
    #1;
    check_val("t5_wr_at_reset", LCD_WR, 1);
    check_val("t5_cs_at_reset", LCD_CS, 1);
    check_val("t5_data_at_reset", LCD_DATA, 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cnt0 = s_word.size();
    repeat (40) @(posedge HCLK);
    #1;
    ahb_read(32'h10, rd); check_val("t5_status", rd, 32'h4);
    check_val("t5_no_strobes", s_word.size() - cnt0, 0);

`ifdef AHBLITE_LCD_IRQ_EN
    // T6: sticky DONE raises IRQ when enabled, write-1 clears it
    ahb_write(32'h00, 32'h08);
    ahb_write(32'h0C, 32'h0077);
    wait_idle("t6_idle");
    check_val("t6_irq_set", IRQ, 1);
    ahb_read(32'h10, rd); check_val("t6_status_done", rd, 32'hC);
    ahb_write(32'h10, 32'h08);
    check_val("t6_irq_clr", IRQ, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
